div_remainder_unit: RTL and testbench

- Consumer end of the divider's divisor interface: runs an unsigned 32-bit sequential restoring division.
- Holds the 64-bit remainder register (Rem_hi:Rem_lo), performs one shift/subtract/restore step per clock and reports quotient/remainder with a start/done handshake.
- Sits beside the divisor register in the PA1 divider datapath; this block captures the divisor itself at start.

---
 rtl/div_remainder_unit.sv | 108 ++++++++++
 tb/tb_div_remainder_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/div_remainder_unit.sv
// Unsigned sequential restoring divider (one quotient bit per clock).
// Holds the double-width remainder register {rem_hi, rem_lo}. The quotient
// bits shift into rem_lo while the partial remainder builds up in rem_hi.
// The divisor is captured locally when a start is accepted.
module div_remainder_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend_in,
  input  logic [WIDTH-1:0] Divisor_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Quotient_out,
  output logic [WIDTH-1:0] Remainder_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0]   rem_sh;
  logic [2*WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]     dvsr;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       diff;
  logic                 last;
  logic                 accept;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  // One restoring step. The bit shifted out of rem_hi is kept as the top bit
  // of the subtraction. Without it, divisors with the MSB set would lose
  // magnitude. When that bit is 1, the difference is non-negative and fits
  // in WIDTH bits.
  always_comb begin
    rem_sh   = rem << 1;
    diff     = {rem[2*WIDTH-1], rem_sh[2*WIDTH-1:WIDTH]} - {1'b0, dvsr};
    rem_step = rem_sh;
    if (!diff[WIDTH]) begin
      rem_step[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
      rem_step[0]               = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs. A zero divisor skips RUN entirely.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (Divisor_in == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands are captured on accept, and one step runs per RUN
  // cycle. Results register on the edge entering DONE, so they are valid
  // together with done. The results hold until a later run overwrites them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem           <= '0;
      dvsr          <= '0;
      cnt           <= '0;
      div_zero      <= 1'b0;
      Quotient_out  <= '0;
      Remainder_out <= '0;
    end else begin
      if (accept) begin
        rem      <= {{WIDTH{1'b0}}, Dividend_in};
        dvsr     <= Divisor_in;
        cnt      <= '0;
        div_zero <= 1'b0;
        if (Divisor_in == '0) begin
          div_zero      <= 1'b1;
          Quotient_out  <= '1;
          Remainder_out <= Dividend_in;
        end
      end else if (state == RUN) begin
        rem <= rem_step;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          Quotient_out  <= rem_step[WIDTH-1:0];
          Remainder_out <= rem_step[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_div_remainder_unit.sv
// Directed bench for div_remainder_unit. Expected results go into a
// scoreboard queue when a start is driven. They are popped and compared
// when done is seen.
module tb_div_remainder_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] Dividend_in, Divisor_in;
  logic         busy, done, div_zero;
  logic [W-1:0] Quotient_out, Remainder_out;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_remainder_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .Dividend_in(Dividend_in), .Divisor_in(Divisor_in),
    .busy(busy), .done(done), .div_zero(div_zero),
    .Quotient_out(Quotient_out), .Remainder_out(Remainder_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse at a negedge. The accept edge ends cycle 0, and
  // samples are taken at the negedges of cycles 1, 2, and so on.
  // If poke is set, a second start (5/5) is pulsed in cycle 10 and must be ignored.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    exp_t e;
    exp_t got;
    int   n;
    e.q  = (b == 0) ? '1 : a / b;
    e.r  = (b == 0) ? a  : a % b;
    e.dz = (b == 0);
    sb.push_back(e);
    start = 1'b1; Dividend_in = a; Divisor_in = b;
    @(negedge clk);
    start = 1'b0; Dividend_in = $urandom; Divisor_in = $urandom;
    n = 1;
    chk("busy_cycle1", busy, (b != 0));
    while (!done && n < 100) begin
      if (poke && n == 10) begin
        start = 1'b1; Dividend_in = 5; Divisor_in = 5;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", n, (b == 0) ? 1 : W + 1);
    got = sb.pop_front();
    chk("quotient", Quotient_out, got.q);
    chk("remainder", Remainder_out, got.r);
    chk("div_zero", div_zero, got.dz);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("quotient_hold", Quotient_out, got.q);
  endtask

  initial begin
    int saw;
    reset = 1'b0; start = 1'b0; Dividend_in = '0; Divisor_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_div_zero", div_zero, 1'b0);
    chk("rst_quotient", Quotient_out, '0);
    chk("rst_remainder", Remainder_out, '0);
    saw = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy) saw++;
    end
    chk("rst_idle_50", saw, 0);

    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_div(32'd3, 32'd7, 1'b0);
    run_div(32'd55, 32'd0, 1'b0);
    run_div(32'd9, 32'd3, 1'b0);
    run_div(32'd1000, 32'd10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom >> (i * 8);
      run_div(a, b, 1'b0);
    end

    // Abort: start 1000/10, ignored start in cycle 10, reset low in cycle 20.
    start = 1'b1; Dividend_in = 32'd1000; Divisor_in = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; Dividend_in = 5; Divisor_in = 5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_pre_abort", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_quotient", Quotient_out, '0);
    chk("abort_remainder", Remainder_out, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw++;
    end
    chk("abort_no_done", saw, 0);
    chk("abort_div_zero", div_zero, 1'b0);
    chk("abort_q_hold", Quotient_out, '0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
